mon_alarm_filter: RTL and testbench

Input conditioning stage between the AGC's raw active-low alarm lines and the monitor status register block. Each alarm line is synchronized to the monitor clock and glitch-filtered, then stretched to a guaranteed minimum width before it is presented downstream. The block also records sticky per-channel glitch flags and the index of the first alarm to assert since the last clear, so that software can diagnose marginal alarm signals.

---
 rtl/mon_alarm_filter_pkg.sv | 33 +++
 rtl/mon_alarm_chan.sv | 106 ++++++++++
 rtl/mon_alarm_filter.sv | 75 +++++++
 tb/tb_mon_alarm_filter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mon_alarm_filter_pkg.sv
// Shared types for the monitor alarm conditioning block: channel FSM states,
// AGC alarm channel indices and the first-alarm priority helper.
package mon_alarm_filter_pkg;

  typedef enum logic [1:0] {
    ALMF_IDLE   = 2'd0,
    ALMF_ASSERT = 2'd1,
    ALMF_HOLD   = 2'd2
  } almf_state_e;

  localparam int ALM_CH_VFAIL = 0;
  localparam int ALM_CH_OSCAL = 1;
  localparam int ALM_CH_SCAFL = 2;
  localparam int ALM_CH_SCDBL = 3;
  localparam int ALM_CH_CTRAL = 4;
  localparam int ALM_CH_TCAL  = 5;
  localparam int ALM_CH_RPTAL = 6;
  localparam int ALM_CH_PAL   = 7;
  localparam int ALM_CH_WATCH = 8;
  localparam int ALM_CH_PIPAL = 9;
  localparam int ALM_CH_WARNF = 10;

  // Lowest set bit wins; returns 0 when nothing is set.
  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mon_alarm_chan.sv
// One alarm channel: two-flop synchronizer, glitch filter and minimum-width
// stretcher. Exposes single-cycle glitch_set / enter_assert strobes.
module mon_alarm_chan
  import mon_alarm_filter_pkg::*;
#(
  parameter int FILTER_CYCLES  = 4,
  parameter int STRETCH_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw_n,
  output logic o_s,
  output logic o_alarm_n,
  output logic o_glitch_set,
  output logic o_enter_assert
);

  localparam int MAXC = (FILTER_CYCLES > STRETCH_CYCLES) ? FILTER_CYCLES : STRETCH_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] F_LAST = CW'(FILTER_CYCLES - 1);
  localparam logic [CW-1:0] S_LAST = CW'(STRETCH_CYCLES - 1);

  logic          r_sync_p0;
  logic          r_sync_p1;
  almf_state_e   r_state;
  almf_state_e   w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_alarm_n;
  logic          w_glitch_set;
  logic          w_enter_assert;

  // stage p0/p1: synchronizer, idles high (no alarm)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_p0 <= 1'b1;
      r_sync_p1 <= 1'b1;
    end else begin
      r_sync_p0 <= i_raw_n;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // stage p2: filter/stretch FSM; alarm_n is decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ALMF_IDLE;
      r_cnt     <= '0;
      r_alarm_n <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_alarm_n <= (w_state_nxt == ALMF_IDLE);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_glitch_set   = 1'b0;
    w_enter_assert = 1'b0;
    case (r_state)
      ALMF_IDLE: begin
        if (!r_sync_p1) begin
          if (r_cnt == F_LAST) begin
            w_state_nxt    = ALMF_ASSERT;
            w_cnt_nxt      = '0;
            w_enter_assert = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end else begin
          w_glitch_set = (r_cnt != '0);
          w_cnt_nxt    = '0;
        end
      end
      ALMF_ASSERT: begin
        if (r_sync_p1) begin
          w_state_nxt = ALMF_HOLD;
          w_cnt_nxt   = '0;
        end
      end
      ALMF_HOLD: begin
        if (!r_sync_p1) begin
          w_state_nxt = ALMF_ASSERT;
          w_cnt_nxt   = '0;
        end else if (r_cnt == S_LAST) begin
          w_state_nxt = ALMF_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = ALMF_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_s            = r_sync_p1;
  assign o_alarm_n      = r_alarm_n;
  assign o_glitch_set   = w_glitch_set;
  assign o_enter_assert = w_enter_assert;

endmodule

// File: rtl/mon_alarm_filter.sv
// Alarm input conditioning for the monitor status registers: per-channel
// filtering, bypass muxing, sticky glitch flags and first-alarm capture.
module mon_alarm_filter
  import mon_alarm_filter_pkg::*;
#(
  parameter int N_ALARMS       = 11,
  parameter int FILTER_CYCLES  = 4,
  parameter int STRETCH_CYCLES = 8,
  parameter logic [N_ALARMS-1:0] BYPASS_MASK = N_ALARMS'(11'b000_1000_0000)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_ALARMS-1:0] alarm_raw_n,
  input  logic                clear,
  output logic [N_ALARMS-1:0] alarm_n,
  output logic [N_ALARMS-1:0] glitch,
  output logic                first_valid,
  output logic [3:0]          first_idx
);

  logic [N_ALARMS-1:0] w_s;
  logic [N_ALARMS-1:0] w_fsm_n;
  logic [N_ALARMS-1:0] w_gset_raw;
  logic [N_ALARMS-1:0] w_enter_raw;
  logic [N_ALARMS-1:0] w_gset;
  logic [N_ALARMS-1:0] w_enter;
  logic [3:0]          w_first_idx;
  logic [N_ALARMS-1:0] r_glitch;
  logic                r_first_valid;
  logic [3:0]          r_first_idx;

  for (genvar i = 0; i < N_ALARMS; i++) begin : g_chan
    mon_alarm_chan #(
      .FILTER_CYCLES (FILTER_CYCLES),
      .STRETCH_CYCLES(STRETCH_CYCLES)
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_raw_n       (alarm_raw_n[i]),
      .o_s           (w_s[i]),
      .o_alarm_n     (w_fsm_n[i]),
      .o_glitch_set  (w_gset_raw[i]),
      .o_enter_assert(w_enter_raw[i])
    );
    // Bypassed channels pass the synchronized line straight through.
    assign alarm_n[i] = BYPASS_MASK[i] ? w_s[i] : w_fsm_n[i];
  end

  assign w_gset      = w_gset_raw  & ~BYPASS_MASK;
  assign w_enter     = w_enter_raw & ~BYPASS_MASK;
  assign w_first_idx = lowest_idx(16'(w_enter));

  // A set event on the same edge as clear takes precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_glitch      <= '0;
      r_first_valid <= 1'b0;
      r_first_idx   <= 4'd0;
    end else begin
      r_glitch <= (r_glitch & ~{N_ALARMS{clear}}) | w_gset;
      if (!r_first_valid && (|w_enter)) begin
        r_first_valid <= 1'b1;
        r_first_idx   <= w_first_idx;
      end else if (clear) begin
        r_first_valid <= 1'b0;
        r_first_idx   <= 4'd0;
      end
    end
  end

  assign glitch      = r_glitch;
  assign first_valid = r_first_valid;
  assign first_idx   = r_first_idx;

endmodule

// File: tb/tb_mon_alarm_filter.sv
// Directed bench for mon_alarm_filter at default parameters; expected values
// are hand-derived edge counts from the raw input change.
module tb_mon_alarm_filter;
  import mon_alarm_filter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [10:0] raw_n;
  logic        clear;
  logic [10:0] alarm_n;
  logic [10:0] glitch;
  logic        first_valid;
  logic [3:0]  first_idx;

  int n_chk;
  int n_pass;

  mon_alarm_filter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alarm_raw_n(raw_n),
    .clear      (clear),
    .alarm_n    (alarm_n),
    .glitch     (glitch),
    .first_valid(first_valid),
    .first_idx  (first_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  initial begin
    logic ok;
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    raw_n = '1;
    clear = 1'b0;
    tick(3);
    chk("rst_alarm_n", 32'(alarm_n), 32'h7FF);
    chk("rst_glitch", 32'(glitch), 32'h0);
    chk("rst_first_valid", 32'(first_valid), 32'h0);
    chk("rst_first_idx", 32'(first_idx), 32'h0);
    #3 rst_n = 1'b1;
    tick(2);

    // Channel 0: 20 low samples, assert after edge 5, release 10 edges after raw high
    raw_n[ALM_CH_VFAIL] = 1'b0;
    tick(5);
    chk("ch0_not_yet", 32'(alarm_n[0]), 32'h1);
    tick(1);
    chk("ch0_assert", 32'(alarm_n[0]), 32'h0);
    chk("ch0_first_valid", 32'(first_valid), 32'h1);
    chk("ch0_first_idx", 32'(first_idx), 32'h0);
    tick(14);
    raw_n[ALM_CH_VFAIL] = 1'b1;
    tick(10);
    chk("ch0_still_low", 32'(alarm_n[0]), 32'h0);
    tick(1);
    chk("ch0_release", 32'(alarm_n[0]), 32'h1);
    chk("ch0_no_glitch", 32'(glitch), 32'h0);
    pulse_clear();
    chk("ch0_clear_fv", 32'(first_valid), 32'h0);

    // Channel 3: 3-sample pulse is filtered and flagged 2 edges after first high sample
    raw_n[ALM_CH_SCDBL] = 1'b0;
    tick(3);
    raw_n[ALM_CH_SCDBL] = 1'b1;
    tick(2);
    chk("ch3_glitch_early", 32'(glitch), 32'h0);
    tick(1);
    chk("ch3_glitch_set", 32'(glitch), 32'h008);
    ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (alarm_n[3] !== 1'b1) ok = 1'b0;
      tick(1);
    end
    chk("ch3_never_asserts", 32'(ok), 32'h1);
    chk("ch3_no_first", 32'(first_valid), 32'h0);
    chk("ch3_glitch_sticky", 32'(glitch), 32'h008);
    pulse_clear();
    chk("ch3_glitch_clear", 32'(glitch), 32'h0);

    // Channels 6 and 2 together: lowest index captured, later ch1 ignored
    raw_n[ALM_CH_RPTAL] = 1'b0;
    raw_n[ALM_CH_SCAFL] = 1'b0;
    tick(6);
    chk("dual_alarm_n", 32'(alarm_n), 32'h7BB);
    chk("dual_first_valid", 32'(first_valid), 32'h1);
    chk("dual_first_idx", 32'(first_idx), 32'h2);
    raw_n[ALM_CH_OSCAL] = 1'b0;
    tick(8);
    chk("ch1_asserted", 32'(alarm_n[1]), 32'h0);
    chk("ch1_idx_held", 32'(first_idx), 32'h2);
    raw_n = '1;
    tick(12);
    chk("dual_released", 32'(alarm_n), 32'h7FF);
    chk("dual_idx_until_clear", 32'(first_idx), 32'h2);
    pulse_clear();
    chk("dual_clear_fv", 32'(first_valid), 32'h0);
    chk("dual_clear_idx", 32'(first_idx), 32'h0);

    // Channel 4: 4-cycle release inside the stretch window leaves no gap
    raw_n[ALM_CH_CTRAL] = 1'b0;
    tick(6);
    chk("ch4_assert", 32'(alarm_n[4]), 32'h0);
    raw_n[ALM_CH_CTRAL] = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      if (alarm_n[4] !== 1'b0) ok = 1'b0;
    end
    raw_n[ALM_CH_CTRAL] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick(1);
      if (alarm_n[4] !== 1'b0) ok = 1'b0;
    end
    chk("ch4_no_gap", 32'(ok), 32'h1);
    chk("ch4_first_idx", 32'(first_idx), 32'h4);
    raw_n[ALM_CH_CTRAL] = 1'b1;
    tick(12);
    chk("ch4_released", 32'(alarm_n[4]), 32'h1);
    chk("ch4_no_glitch", 32'(glitch), 32'h0);
    pulse_clear();

    // PAL bypass: 1-cycle pulse appears for exactly 1 cycle, 2 edges later
    raw_n[ALM_CH_PAL] = 1'b0;
    tick(1);
    raw_n[ALM_CH_PAL] = 1'b1;
    chk("pal_edge0", 32'(alarm_n[7]), 32'h1);
    tick(1);
    chk("pal_low", 32'(alarm_n[7]), 32'h0);
    tick(1);
    chk("pal_high_again", 32'(alarm_n[7]), 32'h1);
    tick(4);
    chk("pal_no_glitch", 32'(glitch), 32'h0);
    chk("pal_no_first", 32'(first_valid), 32'h0);

    // Channel 9: async reset during HOLD, then full latency again
    raw_n[ALM_CH_PIPAL] = 1'b0;
    tick(6);
    chk("ch9_assert", 32'(alarm_n[9]), 32'h0);
    raw_n[ALM_CH_PIPAL] = 1'b1;
    tick(4);
    chk("ch9_hold_low", 32'(alarm_n[9]), 32'h0);
    #3 rst_n = 1'b0;
    #1;
    chk("ch9_async_release", 32'(alarm_n), 32'h7FF);
    chk("ch9_rst_fv", 32'(first_valid), 32'h0);
    raw_n[ALM_CH_PIPAL] = 1'b0;
    tick(2);
    #3 rst_n = 1'b1;
    tick(5);
    chk("ch9_relatency_wait", 32'(alarm_n[9]), 32'h1);
    tick(1);
    chk("ch9_relatency_assert", 32'(alarm_n[9]), 32'h0);
    chk("ch9_first_idx", 32'(first_idx), 32'h9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
